// File: rtl/word_store_sequencer.sv
// Byte-serializing store unit: accepts one 16-bit word and writes it to the
// byte-wide memory bus as two consecutive byte writes at addr and addr+1.
module word_store_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int HIGH_FIRST  = 0,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              byte_sel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(WAIT_STATES);
  localparam logic       HF        = (HIGH_FIRST != 0);

  state_t              state_q;
  logic [3:0]          hold_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         data_q;

  logic                req_ready_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_data_q;
  logic                mem_we_q;
  logic                byte_sel_q;
  logic                busy_q;
  logic                done_q;

  logic [7:0]          req_first_d;
  logic [7:0]          cap_first_d;
  logic [7:0]          cap_second_d;
  logic [ADDR_W-1:0]   addr_plus1_d;
  logic                hold_last_d;

  // Byte ordering is fixed at elaboration; the first byte always lands at addr.
  always_comb begin
    req_first_d  = HF ? req_data[15:8] : req_data[7:0];
    cap_first_d  = HF ? data_q[15:8]   : data_q[7:0];
    cap_second_d = HF ? data_q[7:0]    : data_q[15:8];
    addr_plus1_d = addr_q + ADDR_W'(1);
    hold_last_d  = (hold_q == HOLD_LAST);
  end

  // Outputs are registered alongside the state so each one reflects the state
  // being entered, with no combinational path from the request inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      byte_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= WR0;
            hold_q      <= '0;
            addr_q      <= req_addr;
            data_q      <= req_data;
            req_ready_q <= 1'b0;
            mem_addr_q  <= req_addr;
            mem_data_q  <= req_first_d;
            mem_we_q    <= 1'b1;
            byte_sel_q  <= HF;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end

        WR0: begin
          if (hold_last_d) begin
            state_q    <= WR1;
            hold_q     <= '0;
            mem_addr_q <= addr_plus1_d;
            mem_data_q <= cap_second_d;
            byte_sel_q <= ~HF;
          end else begin
            hold_q     <= hold_q + 4'd1;
            mem_addr_q <= addr_q;
            mem_data_q <= cap_first_d;
            byte_sel_q <= HF;
          end
        end

        WR1: begin
          if (hold_last_d) begin
            state_q    <= DONE;
            hold_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            byte_sel_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end

        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          hold_q      <= '0;
          req_ready_q <= 1'b1;
          mem_addr_q  <= '0;
          mem_data_q  <= '0;
          mem_we_q    <= 1'b0;
          byte_sel_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign byte_sel  = byte_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_word_store_sequencer.sv
// Directed bench for word_store_sequencer: three instances cover the default
// configuration, a wait-state build and a high-byte-first build.
module tb_word_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [15:0] req_data;

  logic        d0_ready, d0_we, d0_bs, d0_busy, d0_done;
  logic [15:0] d0_addr;
  logic [7:0]  d0_data;
  logic        d1_ready, d1_we, d1_bs, d1_busy, d1_done;
  logic [15:0] d1_addr;
  logic [7:0]  d1_data;
  logic        d2_ready, d2_we, d2_bs, d2_busy, d2_done;
  logic [15:0] d2_addr;
  logic [7:0]  d2_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  word_store_sequencer #(.ADDR_W(16), .HIGH_FIRST(0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d0_ready),
    .req_addr(req_addr), .req_data(req_data), .mem_addr(d0_addr),
    .mem_data(d0_data), .mem_we(d0_we), .byte_sel(d0_bs), .busy(d0_busy),
    .done(d0_done)
  );

  word_store_sequencer #(.ADDR_W(16), .HIGH_FIRST(0), .WAIT_STATES(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d1_ready),
    .req_addr(req_addr), .req_data(req_data), .mem_addr(d1_addr),
    .mem_data(d1_data), .mem_we(d1_we), .byte_sel(d1_bs), .busy(d1_busy),
    .done(d1_done)
  );

  word_store_sequencer #(.ADDR_W(16), .HIGH_FIRST(1), .WAIT_STATES(0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d2_ready),
    .req_addr(req_addr), .req_data(req_data), .mem_addr(d2_addr),
    .mem_data(d2_data), .mem_we(d2_we), .byte_sel(d2_bs), .busy(d2_busy),
    .done(d2_done)
  );

  // Packed view: {we, addr, data, byte_sel, busy, done, ready}
  function automatic logic [28:0] pk(input logic we, input logic [15:0] a,
                                     input logic [7:0] d, input logic bs,
                                     input logic bz, input logic dn,
                                     input logic rd);
    return {we, a, d, bs, bz, dn, rd};
  endfunction

  function automatic logic [28:0] obs0();
    return pk(d0_we, d0_addr, d0_data, d0_bs, d0_busy, d0_done, d0_ready);
  endfunction

  function automatic logic [28:0] obs1();
    return pk(d1_we, d1_addr, d1_data, d1_bs, d1_busy, d1_done, d1_ready);
  endfunction

  function automatic logic [28:0] obs2();
    return pk(d2_we, d2_addr, d2_data, d2_bs, d2_busy, d2_done, d2_ready);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] exp;
    req_addr = 16'h1234;
    req_data = 16'h5678;
    rst = 1'b1;
    req_valid = 1'b1;
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL reset_d0 got=%h want=%h", obs0(), exp);
    end
    tick();
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL reset_valid_ignored got=%h want=%h", obs0(), exp);
    end
    n_cmp++;
    if (obs2() !== exp) begin
      n_err++; $display("FAIL reset_d2 got=%h want=%h", obs2(), exp);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    $display("txn reset: outputs idle after reset");
  endtask

  task automatic test_basic_store();
    logic [28:0] exp;
    do_reset();
    req_valid = 1'b1; req_addr = 16'h0010; req_data = 16'hABCD;
    tick();
    req_valid = 1'b0;
    exp = pk(1'b1, 16'h0010, 8'hCD, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL basic_wr0 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b1, 16'h0011, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL basic_wr1 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL basic_done got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL basic_idle got=%h want=%h", obs0(), exp);
    end
    $display("txn basic: 0xABCD -> 0x0010");
  endtask

  task automatic test_addr_wrap();
    logic [28:0] exp;
    do_reset();
    req_valid = 1'b1; req_addr = 16'hFFFF; req_data = 16'h1234;
    tick();
    req_valid = 1'b0;
    exp = pk(1'b1, 16'hFFFF, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL wrap_wr0 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b1, 16'h0000, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL wrap_wr1 got=%h want=%h", obs0(), exp);
    end
    tick();
    tick();
    $display("txn wrap: 0x1234 -> 0xFFFF");
  endtask

  task automatic test_wait_states();
    logic [28:0] exp;
    int we_cycles;
    do_reset();
    req_valid = 1'b1; req_addr = 16'h0100; req_data = 16'h00FF;
    tick();
    req_valid = 1'b0;
    we_cycles = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i <= 3)      exp = pk(1'b1, 16'h0100, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (i <= 6) exp = pk(1'b1, 16'h0101, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      else             exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      if (d1_we === 1'b1) we_cycles++;
      n_cmp++;
      if (obs1() !== exp) begin
        n_err++; $display("FAIL wait_cycle%0d got=%h want=%h", i, obs1(), exp);
      end
      tick();
    end
    n_cmp++;
    if (we_cycles !== 6) begin
      n_err++; $display("FAIL wait_we_count got=%0d want=6", we_cycles);
    end
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs1() !== exp) begin
      n_err++; $display("FAIL wait_idle got=%h want=%h", obs1(), exp);
    end
    $display("txn wait2: 0x00FF -> 0x0100, we cycles %0d", we_cycles);
  endtask

  task automatic test_high_first();
    logic [28:0] exp;
    do_reset();
    req_valid = 1'b1; req_addr = 16'h0020; req_data = 16'hABCD;
    tick();
    req_valid = 1'b0;
    exp = pk(1'b1, 16'h0020, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs2() !== exp) begin
      n_err++; $display("FAIL hf_wr0 got=%h want=%h", obs2(), exp);
    end
    tick();
    exp = pk(1'b1, 16'h0021, 8'hCD, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs2() !== exp) begin
      n_err++; $display("FAIL hf_wr1 got=%h want=%h", obs2(), exp);
    end
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs2() !== exp) begin
      n_err++; $display("FAIL hf_done got=%h want=%h", obs2(), exp);
    end
    tick();
    $display("txn high_first: 0xABCD -> 0x0020");
  endtask

  task automatic test_back_to_back();
    logic [28:0] exp;
    do_reset();
    req_valid = 1'b1; req_addr = 16'h0030; req_data = 16'h1111;
    tick();
    req_addr = 16'h0050; req_data = 16'h2222;
    exp = pk(1'b1, 16'h0030, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL b2b_wr0 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b1, 16'h0031, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL b2b_wr1 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL b2b_done got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL b2b_idle got=%h want=%h", obs0(), exp);
    end
    tick();
    req_valid = 1'b0;
    exp = pk(1'b1, 16'h0050, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL b2b_second_wr0 got=%h want=%h", obs0(), exp);
    end
    tick();
    tick();
    tick();
    $display("txn back_to_back: 0x1111 -> 0x0030 then 0x2222 -> 0x0050");
  endtask

  task automatic test_reset_abort();
    logic [28:0] exp;
    do_reset();
    req_valid = 1'b1; req_addr = 16'h0040; req_data = 16'h5A5A;
    tick();
    req_valid = 1'b0;
    tick();
    exp = pk(1'b1, 16'h0041, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL abort_wr1 got=%h want=%h", obs0(), exp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = pk(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL abort_after_rst got=%h want=%h", obs0(), exp);
    end
    tick();
    n_cmp++;
    if (d0_done !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done got=%b want=0", d0_done);
    end
    req_valid = 1'b1; req_addr = 16'h0060; req_data = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    exp = pk(1'b1, 16'h0060, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL abort_new_wr0 got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = pk(1'b1, 16'h0061, 8'hBE, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++; $display("FAIL abort_new_wr1 got=%h want=%h", obs0(), exp);
    end
    tick();
    n_cmp++;
    if (d0_done !== 1'b1) begin
      n_err++; $display("FAIL abort_new_done got=%b want=1", d0_done);
    end
    tick();
    $display("txn reset_abort: store to 0x0040 aborted, 0xBEEF -> 0x0060");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    #2;
    test_reset();
    test_basic_store();
    test_addr_wrap();
    test_wait_states();
    test_high_first();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
